// File: rtl/collatz_host_if.sv
// Requester- and tile-side signal bundle for collatz_host.
// The master modport is the requester/tile environment and the slave modport is the host.
interface collatz_host_if #(
    parameter int unsigned BITS = 32
);
    logic            start;
    logic [BITS-1:0] number;
    logic            ready;
    logic            done;
    logic            error;
    logic [BITS-1:0] orbit_len;
    logic [BITS-1:0] path_record;
    logic [7:0]      dev_data;
    logic [7:0]      dev_rdata;
    logic [7:0]      dev_ctrl;
    logic [7:0]      dev_ctrl_oe;
    logic            dev_busy;

    modport master (
        output start, number, dev_rdata, dev_busy,
        input  ready, done, error, orbit_len, path_record,
        input  dev_data, dev_ctrl, dev_ctrl_oe
    );

    modport slave (
        input  start, number, dev_rdata, dev_busy,
        output ready, done, error, orbit_len, path_record,
        output dev_data, dev_ctrl, dev_ctrl_oe
    );
endinterface

// File: rtl/collatz_host.sv
// Host-side initiator for the Collatz tile: writes the start value byte-wise, triggers
// COMPUTE, waits out the busy pulse, then reads back orbit length and path record.
module collatz_host #(
    parameter int unsigned BITS    = 32,
    parameter int unsigned TIMEOUT = 1048576
) (
    input logic           clk,
    input logic           reset,
    collatz_host_if.slave bus
);
    localparam int unsigned NB = BITS / 8;
    localparam int unsigned KW = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned IW = $clog2(2 * NB + 1);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    localparam logic [KW-1:0] K_LAST       = KW'(NB - 1);
    localparam logic [IW-1:0] R_NB         = IW'(NB);
    localparam logic [IW-1:0] R_LAST_ISSUE = IW'(2 * NB - 1);
    localparam logic [IW-1:0] R_END        = IW'(2 * NB);
    localparam logic [CW-1:0] C_LIMIT      = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_GO,
        S_WAIT_HI,
        S_WAIT_LO,
        S_READ,
        S_DONE
    } state_t;

    state_t                state;
    logic [NB-1:0][7:0]    num_q;
    logic [NB-1:0][7:0]    orbit_q;
    logic [NB-1:0][7:0]    rec_q;
    logic [KW-1:0]         wr_k;
    logic [IW-1:0]         rd_n;
    logic [CW-1:0]         cnt;

    logic [IW-1:0]         cap_n;
    logic [IW-1:0]         nxt_n;
    logic                  cap_sel;
    logic                  nxt_sel;
    logic [KW-1:0]         cap_k;
    logic [KW-1:0]         nxt_k;

    assign bus.orbit_len   = orbit_q;
    assign bus.path_record = rec_q;

    // rd_n counts READ cycles; the byte captured now was issued one cycle earlier.
    always_comb begin
        cap_n   = rd_n - IW'(1);
        nxt_n   = rd_n + IW'(1);
        cap_sel = (cap_n >= R_NB);
        nxt_sel = (nxt_n >= R_NB);
        cap_k   = KW'(cap_sel ? cap_n - R_NB : cap_n);
        nxt_k   = KW'(nxt_sel ? nxt_n - R_NB : nxt_n);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= S_IDLE;
            bus.ready       <= 1'b1;
            bus.done        <= 1'b0;
            bus.error       <= 1'b0;
            bus.dev_data    <= '0;
            bus.dev_ctrl    <= 8'h80;
            bus.dev_ctrl_oe <= '1;
            num_q           <= '0;
            orbit_q         <= '0;
            rec_q           <= '0;
            wr_k            <= '0;
            rd_n            <= '0;
            cnt             <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        num_q        <= bus.number;
                        bus.error    <= 1'b0;
                        bus.ready    <= 1'b0;
                        bus.dev_data <= bus.number[7:0];
                        bus.dev_ctrl <= 8'h00;
                        wr_k         <= '0;
                        state        <= S_WRITE;
                    end
                end

                S_WRITE: begin
                    if (wr_k == K_LAST) begin
                        bus.dev_ctrl <= 8'h40;
                        state        <= S_GO;
                    end else begin
                        wr_k         <= wr_k + KW'(1);
                        bus.dev_ctrl <= {4'h0, 4'(wr_k + KW'(1))};
                        bus.dev_data <= num_q[wr_k + KW'(1)];
                    end
                end

                S_GO: begin
                    bus.dev_ctrl    <= 8'h80;
                    bus.dev_ctrl_oe <= 8'h7F;
                    cnt             <= '0;
                    state           <= S_WAIT_HI;
                end

                S_WAIT_HI: begin
                    if (bus.dev_busy) begin
                        cnt   <= '0;
                        state <= S_WAIT_LO;
                    end else if (cnt == C_LIMIT) begin
                        bus.error       <= 1'b1;
                        bus.done        <= 1'b1;
                        bus.dev_ctrl_oe <= '1;
                        state           <= S_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                S_WAIT_LO: begin
                    if (!bus.dev_busy) begin
                        bus.dev_ctrl_oe <= '1;
                        bus.dev_ctrl    <= 8'h80;
                        rd_n            <= '0;
                        state           <= S_READ;
                    end else if (cnt == C_LIMIT) begin
                        bus.error       <= 1'b1;
                        bus.done        <= 1'b1;
                        bus.dev_ctrl_oe <= '1;
                        state           <= S_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                S_READ: begin
                    if (rd_n != '0) begin
                        if (cap_sel) rec_q[cap_k] <= bus.dev_rdata;
                        else         orbit_q[cap_k] <= bus.dev_rdata;
                    end
                    if (rd_n == R_END) begin
                        bus.done <= 1'b1;
                        state    <= S_DONE;
                    end else if (rd_n == R_LAST_ISSUE) begin
                        bus.dev_ctrl <= 8'h80;
                    end else begin
                        bus.dev_ctrl <= {1'b1, 2'b00, nxt_sel, 4'(nxt_k)};
                    end
                    rd_n <= nxt_n;
                end

                S_DONE: begin
                    bus.ready <= 1'b1;
                    state     <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_collatz_host.sv
// Bench for collatz_host: behavioural tile models on two hosts (long and short TIMEOUT),
// table vectors, random values against an arithmetic Collatz reference, corner sequences.
module tb_collatz_host;
    localparam int unsigned BITS = 32;
    localparam int unsigned NB   = BITS / 8;
    localparam int unsigned TO_A = 1024;
    localparam int unsigned TO_B = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    collatz_host_if #(.BITS(BITS)) bus_a ();
    collatz_host_if #(.BITS(BITS)) bus_b ();

    collatz_host #(.BITS(BITS), .TIMEOUT(TO_A)) dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
    collatz_host #(.BITS(BITS), .TIMEOUT(TO_B)) dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

    // Tile model: index 0 serves dut_a, index 1 serves dut_b.
    logic [7:0]  t_ctrl  [2];
    logic [7:0]  t_data  [2];
    logic [7:0]  t_rdata [2] = '{8'h00, 8'h00};
    logic        t_busy  [2] = '{1'b0, 1'b0};
    logic [31:0] t_opnd  [2] = '{32'd0, 32'd0};
    logic [31:0] t_len   [2] = '{32'd0, 32'd0};
    logic [31:0] t_rec   [2] = '{32'd0, 32'd0};
    logic [63:0] t_x     [2] = '{64'd0, 64'd0};

    assign t_ctrl[0] = bus_a.dev_ctrl;
    assign t_ctrl[1] = bus_b.dev_ctrl;
    assign t_data[0] = bus_a.dev_data;
    assign t_data[1] = bus_b.dev_data;
    assign bus_a.dev_rdata = t_rdata[0];
    assign bus_b.dev_rdata = t_rdata[1];
    assign bus_a.dev_busy  = t_busy[0];
    assign bus_b.dev_busy  = t_busy[1];

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            automatic logic [63:0] nx;
            automatic int sh = 8 * int'(t_ctrl[g][1:0]);
            t_rdata[g] <= 8'((t_ctrl[g][4] ? t_rec[g] : t_len[g]) >> (8 * int'(t_ctrl[g][3:0])));
            if (t_ctrl[g][7:6] == 2'b00)
                t_opnd[g] <= (t_opnd[g] & ~(32'hFF << sh)) | (32'(t_data[g]) << sh);
            if (t_ctrl[g] == 8'h40) begin
                t_busy[g] <= 1'b1;
                t_x[g]    <= 64'(t_opnd[g]);
                t_len[g]  <= 32'd0;
                t_rec[g]  <= t_opnd[g];
            end else if (t_busy[g]) begin
                t_len[g] <= t_len[g] + 32'd1;
                if (t_x[g] == 64'd1) begin
                    t_busy[g] <= 1'b0;
                end else begin
                    nx = t_x[g][0] ? 3 * t_x[g] + 1 : t_x[g] >> 1;
                    t_x[g] <= nx;
                    if (nx > 64'(t_rec[g])) t_rec[g] <= 32'(nx);
                end
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // Orbit length counts every value visited including the start; record is the maximum.
    function automatic void ref_collatz(input logic [31:0] n, output logic [31:0] len,
                                        output logic [31:0] rec);
        longint unsigned x = 64'(n);
        len = 1;
        rec = n;
        while (x != 1) begin
            x = (x % 2 == 1) ? 3 * x + 1 : x / 2;
            len++;
            if (x > 64'(rec)) rec = 32'(x);
        end
    endfunction

    task automatic drive(input int sel, input logic s, input logic [31:0] n);
        if (sel == 0) begin bus_a.start = s; bus_a.number = n; end
        else          begin bus_b.start = s; bus_b.number = n; end
    endtask

    task automatic run(input int sel, input logic [31:0] n, input int exp_lat, input logic exp_err,
                       input logic [31:0] exp_orb, input logic [31:0] exp_rec, input bit spam,
                       input string tag);
        int c;
        int bad = 0;
        int wait_end = exp_err ? exp_lat - 1 : exp_lat - int'(2 * NB + 2);
        logic [7:0] ctrl, oe, data;
        logic rdy, dn, er;
        logic [31:0] orb, rec;
        @(negedge clk);
        drive(sel, 1'b1, n);
        @(negedge clk);
        drive(sel, 1'b0, n);
        for (c = 1; c <= 3000; c++) begin
            ctrl = sel ? bus_b.dev_ctrl : bus_a.dev_ctrl;
            oe   = sel ? bus_b.dev_ctrl_oe : bus_a.dev_ctrl_oe;
            data = sel ? bus_b.dev_data : bus_a.dev_data;
            rdy  = sel ? bus_b.ready : bus_a.ready;
            dn   = sel ? bus_b.done : bus_a.done;
            er   = sel ? bus_b.error : bus_a.error;
            orb  = sel ? bus_b.orbit_len : bus_a.orbit_len;
            rec  = sel ? bus_b.path_record : bus_a.path_record;
            if (rdy || (er && !dn)) bad++;
            if (c <= int'(NB)) begin
                if (ctrl != 8'(c - 1) || oe != 8'hFF || data != 8'(n >> (8 * (c - 1)))) bad++;
            end else if (c == int'(NB) + 1) begin
                if (ctrl != 8'h40 || oe != 8'hFF) bad++;
            end else if (c <= wait_end) begin
                if (ctrl != 8'h80 || oe != 8'h7F) bad++;
            end else begin
                if (!ctrl[7] || oe != 8'hFF) bad++;
            end
            if (dn) break;
            if (spam) drive(sel, (c >= 20 && c <= 40 && c % 5 == 0), 32'd5);
            @(negedge clk);
        end
        drive(sel, 1'b0, n);
        chk({tag, " latency"}, 64'(c), 64'(exp_lat));
        chk({tag, " error"}, 64'(er), 64'(exp_err));
        chk({tag, " orbit_len"}, 64'(orb), 64'(exp_orb));
        chk({tag, " path_record"}, 64'(rec), 64'(exp_rec));
        chk({tag, " drive"}, 64'(bad), 64'd0);
        @(negedge clk);
        rdy = sel ? bus_b.ready : bus_a.ready;
        dn  = sel ? bus_b.done : bus_a.done;
        chk({tag, " ready after done"}, {62'd0, rdy, dn}, 64'b10);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " ready"}, 64'(bus_a.ready), 64'd1);
        chk({tag, " done"}, 64'(bus_a.done), 64'd0);
        chk({tag, " error"}, 64'(bus_a.error), 64'd0);
        chk({tag, " orbit_len"}, 64'(bus_a.orbit_len), 64'd0);
        chk({tag, " path_record"}, 64'(bus_a.path_record), 64'd0);
        chk({tag, " dev_ctrl"}, 64'(bus_a.dev_ctrl), 64'h80);
        chk({tag, " dev_ctrl_oe"}, 64'(bus_a.dev_ctrl_oe), 64'hFF);
        chk({tag, " dev_data"}, 64'(bus_a.dev_data), 64'h00);
    endtask

    typedef struct {
        logic [31:0] n;
        logic [31:0] orb;
        logic [31:0] rec;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [31:0] rn, rl, rr;
        int extra;
        tbl[0] = '{32'd27,         32'd112, 32'd9232};
        tbl[1] = '{32'd1,          32'd1,   32'd1};
        tbl[2] = '{32'd7,          32'd17,  32'd52};
        tbl[3] = '{32'd6,          32'd9,   32'd16};
        tbl[4] = '{32'd2,          32'd2,   32'd2};
        tbl[5] = '{32'd3,          32'd8,   32'd16};
        tbl[6] = '{32'h0000_0100,  32'd9,   32'h0000_0100};
        tbl[7] = '{32'h0001_0000,  32'd17,  32'h0001_0000};
        tbl[8] = '{32'h0100_0000,  32'd25,  32'h0100_0000};
        tbl[9] = '{32'h8000_0000,  32'd32,  32'h8000_0000};

        reset = 1'b1;
        drive(0, 1'b0, 32'd0);
        drive(1, 1'b0, 32'd0);
        repeat (3) @(negedge clk);
        chk_idle("reset");
        reset = 1'b0;
        @(negedge clk);

        foreach (tbl[i])
            run(0, tbl[i].n, int'(3 * NB + 4) + int'(tbl[i].orb), 1'b0, tbl[i].orb, tbl[i].rec, 1'b0,
                $sformatf("vec%0d", i));

        for (int i = 0; i < 20; i++) begin
            rn = $urandom_range(1000, 1);
            ref_collatz(rn, rl, rr);
            run(0, rn, int'(3 * NB + 4) + int'(rl), 1'b0, rl, rr, 1'b0, $sformatf("rand%0d", i));
        end

        run(0, 32'd27, int'(3 * NB + 4) + 112, 1'b0, 32'd112, 32'd9232, 1'b1, "spam");
        extra = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus_a.done) extra++;
        end
        chk("spam single done", 64'(extra), 64'd0);

        run(1, 32'd6, int'(3 * NB + 4) + 9, 1'b0, 32'd9, 32'd16, 1'b0, "pre_timeout");
        run(1, 32'd0, int'(NB + 3 + TO_B), 1'b1, 32'd9, 32'd16, 1'b0, "timeout");
        repeat (4) @(negedge clk);
        chk("error held", 64'(bus_b.error), 64'd1);
        run(1, 32'd3, int'(3 * NB + 4) + 8, 1'b0, 32'd8, 32'd16, 1'b0, "after_timeout");

        @(negedge clk);
        drive(0, 1'b1, 32'd6);
        @(negedge clk);
        drive(0, 1'b0, 32'd6);
        repeat (17) @(negedge clk);
        chk("read byte 2 addr", 64'(bus_a.dev_ctrl), 64'h82);
        reset = 1'b1;
        @(negedge clk);
        chk_idle("mid_reset");
        reset = 1'b0;
        @(negedge clk);
        run(0, 32'd7, int'(3 * NB + 4) + 17, 1'b0, 32'd17, 32'd52, 1'b0, "post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
